// File: rtl/adxl345_seq.sv
// ADXL345 register sequencer: DEVID check, init table, then periodic XYZ bursts
// over a single-outstanding req/ack PHY interface.
module adxl345_seq #(
  parameter int          SAMPLE_DIV      = 5000,
  parameter logic [7:0]  BW_RATE_VAL     = 8'h0A,
  parameter logic [7:0]  DATA_FORMAT_VAL = 8'h40,
  parameter int          ACK_TIMEOUT     = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  output logic        req_o,
  output logic        rw_no,
  output logic [5:0]  addr_o,
  output logic [7:0]  wr_data_o,
  input  logic        ack_i,
  input  logic [7:0]  rd_data_i,
  output logic [15:0] data_x_o,
  output logic [15:0] data_y_o,
  output logic [15:0] data_z_o,
  output logic        data_valid_o,
  output logic        init_done_o,
  output logic        busy_o,
  output logic        error_o
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TIMEOUT);
  localparam logic [19:0]   PER_LOAD = 20'(SAMPLE_DIV);

  // each issue state is immediately followed by its wait state in the encoding
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_DEVID   = 4'd1;
  localparam logic [3:0] S_DEVID_W = 4'd2;
  localparam logic [3:0] S_INIT    = 4'd3;
  localparam logic [3:0] S_INIT_W  = 4'd4;
  localparam logic [3:0] S_SLEEP   = 4'd5;
  localparam logic [3:0] S_READ    = 4'd6;
  localparam logic [3:0] S_READ_W  = 4'd7;
  localparam logic [3:0] S_ERROR   = 4'd8;

  logic [3:0]      state;
  logic [2:0]      idx;
  logic [19:0]     per_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [4:0][7:0] stage;

  logic       is_issue, in_wait;
  logic       iss_rw;
  logic [5:0] iss_addr;
  logic [7:0] iss_data;

  assign is_issue = (state == S_DEVID) || (state == S_INIT) || (state == S_READ);
  assign in_wait  = (state == S_DEVID_W) || (state == S_INIT_W) || (state == S_READ_W);

  always_comb begin
    iss_rw   = 1'b1;
    iss_addr = 6'h00;
    iss_data = 8'h00;
    case (state)
      S_INIT: begin
        iss_rw = 1'b0;
        case (idx)
          3'd0:    begin iss_addr = 6'h2C; iss_data = BW_RATE_VAL;     end
          3'd1:    begin iss_addr = 6'h31; iss_data = DATA_FORMAT_VAL; end
          default: begin iss_addr = 6'h2D; iss_data = 8'h08;           end
        endcase
      end
      S_READ:  iss_addr = 6'h32 + {3'b000, idx};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      idx          <= '0;
      per_cnt      <= '0;
      tmo_cnt      <= '0;
      stage        <= '0;
      req_o        <= 1'b0;
      rw_no        <= 1'b0;
      addr_o       <= '0;
      wr_data_o    <= '0;
      data_x_o     <= '0;
      data_y_o     <= '0;
      data_z_o     <= '0;
      data_valid_o <= 1'b0;
      init_done_o  <= 1'b0;
      busy_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      req_o        <= 1'b0;
      data_valid_o <= 1'b0;
      if (is_issue) begin
        if (!enable_i) begin
          state       <= S_IDLE;
          init_done_o <= 1'b0;
        end else begin
          req_o     <= 1'b1;
          busy_o    <= 1'b1;
          rw_no     <= iss_rw;
          addr_o    <= iss_addr;
          wr_data_o <= iss_data;
          tmo_cnt   <= TMO_LOAD;
          state     <= state + 4'd1;
        end
      end else if (in_wait) begin
        if (ack_i) begin
          busy_o <= 1'b0;
          if (!enable_i) begin
            state       <= S_IDLE;
            init_done_o <= 1'b0;
          end else begin
            case (state)
              S_DEVID_W: begin
                if (rd_data_i == 8'hE5) begin
                  state <= S_INIT;
                  idx   <= '0;
                end else begin
                  error_o <= 1'b1;
                  state   <= S_ERROR;
                end
              end
              S_INIT_W: begin
                if (idx == 3'd2) begin
                  init_done_o <= 1'b1;
                  per_cnt     <= PER_LOAD;
                  state       <= S_SLEEP;
                end else begin
                  idx   <= idx + 3'd1;
                  state <= S_INIT;
                end
              end
              default: begin
                // sixth byte: publish the whole triple in one edge
                if (idx == 3'd5) begin
                  data_x_o     <= {stage[1], stage[0]};
                  data_y_o     <= {stage[3], stage[2]};
                  data_z_o     <= {rd_data_i, stage[4]};
                  data_valid_o <= 1'b1;
                  per_cnt      <= PER_LOAD;
                  state        <= S_SLEEP;
                end else begin
                  stage[idx] <= rd_data_i;
                  idx        <= idx + 3'd1;
                  state      <= S_READ;
                end
              end
            endcase
          end
        end else if (tmo_cnt <= TW'(1)) begin
          tmo_cnt <= '0;
          error_o <= 1'b1;
          busy_o  <= 1'b0;
          state   <= S_ERROR;
        end else begin
          tmo_cnt <= tmo_cnt - TW'(1);
        end
      end else begin
        case (state)
          S_IDLE: if (enable_i) state <= S_DEVID;
          S_SLEEP: begin
            if (!enable_i) begin
              state       <= S_IDLE;
              init_done_o <= 1'b0;
            end else if (per_cnt <= 20'd1) begin
              per_cnt <= '0;
              idx     <= '0;
              state   <= S_READ;
            end else begin
              per_cnt <= per_cnt - 20'd1;
            end
          end
          S_ERROR: begin
            if (!enable_i) begin
              state       <= S_IDLE;
              error_o     <= 1'b0;
              init_done_o <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adxl345_seq.sv
// Bench for adxl345_seq: randomized-latency PHY model, sensor register array
// and transaction log checked against the expected register traffic.
module tb_adxl345_seq;
  localparam int SD  = 10;
  localparam int TMO = 64;

  logic        clk = 1'b0, rst_i = 1'b1, enable_i = 1'b0, ack_i = 1'b0;
  logic [7:0]  rd_data_i = 8'h00;
  logic        req_o, rw_no, data_valid_o, init_done_o, busy_o, error_o;
  logic [5:0]  addr_o;
  logic [7:0]  wr_data_o;
  logic [15:0] data_x_o, data_y_o, data_z_o;

  adxl345_seq #(.SAMPLE_DIV(SD), .BW_RATE_VAL(8'h0A), .DATA_FORMAT_VAL(8'h40),
                .ACK_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .req_o(req_o), .rw_no(rw_no),
    .addr_o(addr_o), .wr_data_o(wr_data_o), .ack_i(ack_i), .rd_data_i(rd_data_i),
    .data_x_o(data_x_o), .data_y_o(data_y_o), .data_z_o(data_z_o),
    .data_valid_o(data_valid_o), .init_done_o(init_done_o), .busy_o(busy_o),
    .error_o(error_o));

  initial forever #5 clk = ~clk;

  typedef struct { bit rw; logic [5:0] addr; logic [7:0] wd; } txn_t;
  txn_t       log_q[$];
  txn_t       cur;
  logic [7:0] regs [64];
  int passed = 0, total = 0;
  int cyc = 0, last_ack_cyc = -100, last_req_cyc = -100, cnt_down = 0, dv_cnt = 0;
  bit noack = 0, pend = 0, prev_req = 0, prev_dv = 0;
  logic [15:0] ex, ey, ez;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [14:0] key(txn_t t);
    return t.rw ? {1'b1, t.addr, 8'h00} : {1'b0, t.addr, t.wd};
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // XYZ words as the sensor would present them: {high byte, low byte}
  task automatic load_sensor(input logic [7:0] b [6]);
    for (int i = 0; i < 6; i++) regs[6'h32 + i] = b[i];
    ex = {b[1], b[0]}; ey = {b[3], b[2]}; ez = {b[5], b[4]};
  endtask

  task automatic random_sensor();
    logic [7:0] b [6];
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    load_sensor(b);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_req"}, req_o, 0);       check({tag, "_busy"}, busy_o, 0);
    check({tag, "_err"}, error_o, 0);     check({tag, "_init"}, init_done_o, 0);
    check({tag, "_dv"}, data_valid_o, 0); check({tag, "_x"}, data_x_o, 0);
    check({tag, "_y"}, data_y_o, 0);      check({tag, "_z"}, data_z_o, 0);
  endtask

  // PHY model and protocol monitor
  always @(negedge clk) begin
    cyc++;
    ack_i = 1'b0;
    if (rst_i) begin
      cnt_down = 0; pend = 0; prev_req = 0; prev_dv = 0; last_ack_cyc = -100;
    end else begin
      if (cnt_down > 0) begin
        cnt_down--;
        if (cnt_down == 0) begin
          check("attr_held", {rw_no, addr_o, wr_data_o}, {cur.rw, cur.addr, cur.wd});
          ack_i = 1'b1;
          rd_data_i = regs[addr_o];
          last_ack_cyc = cyc;
        end
      end
      if (!busy_o) pend = 0;
      if (req_o) begin
        check("req_single", prev_req, 0);
        check("one_outstanding", pend, 0);
        check("turnaround", (cyc - last_ack_cyc) >= 2, 1);
        check("busy_at_req", busy_o, 1);
        cur = '{rw: rw_no, addr: addr_o, wd: wr_data_o};
        log_q.push_back(cur);
        last_req_cyc = cyc;
        pend = 1;
        if (!noack) cnt_down = $urandom_range(6, 1);
      end
      prev_req = req_o;
      if (data_valid_o) begin
        check("dv_pulse", prev_dv, 0);
        dv_cnt++;
      end
      prev_dv = data_valid_o;
    end
  end

  initial begin
    automatic logic [14:0] exp_init [4] = '{{1'b1, 6'h00, 8'h00}, {1'b0, 6'h2C, 8'h0A},
                                            {1'b0, 6'h31, 8'h40}, {1'b0, 6'h2D, 8'h08}};
    automatic logic [7:0] dir_b [6] = '{8'h01, 8'h80, 8'hFF, 8'h7F, 8'h34, 8'h12};
    int sz, dvc, t0;
    for (int i = 0; i < 64; i++) regs[i] = 8'h00;

    repeat (3) tick();
    check_zero("reset");

    // bring-up: DEVID then init table
    rst_i = 1'b0; regs[0] = 8'hE5; load_sensor(dir_b); enable_i = 1'b1;
    for (int i = 0; i < 600 && !init_done_o; i++) tick();
    check("init_done", init_done_o, 1);
    check("init_after_ack", cyc - last_ack_cyc, 1);
    check("init_txn_cnt", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) check($sformatf("init_txn%0d", i), key(log_q[i]), exp_init[i]);

    // directed burst then random bursts
    for (int b = 0; b < 4; b++) begin
      if (b > 0) random_sensor();
      sz = log_q.size();
      for (int i = 0; i < 100 && log_q.size() == sz; i++) tick();
      check("burst_gap", last_req_cyc - last_ack_cyc, SD + 2);
      dvc = dv_cnt;
      for (int i = 0; i < 200 && dv_cnt == dvc; i++) tick();
      check("dv_seen", data_valid_o, 1);
      check("dv_after_ack", cyc - last_ack_cyc, 1);
      check("data_x", data_x_o, ex);
      check("data_y", data_y_o, ey);
      check("data_z", data_z_o, ez);
      for (int i = 0; i < 6; i++)
        check($sformatf("rd_addr%0d", i), key(log_q[log_q.size() - 6 + i]), {1'b1, 6'h32 + 6'(i), 8'h00});
      tick();
      check("dv_low", data_valid_o, 0);
    end

    // drop enable during the third read of a burst
    begin
      logic [15:0] px, py, pz;
      px = ex; py = ey; pz = ez;
      random_sensor();
      for (int i = 0; i < 200 && !(req_o && addr_o == 6'h34); i++) tick();
      check("third_read_req", {req_o, addr_o}, {1'b1, 6'h34});
      enable_i = 1'b0; sz = log_q.size(); dvc = dv_cnt; t0 = cyc;
      repeat (40) tick();
      check("drop_ack_done", last_ack_cyc > t0, 1);
      check("drop_no_dv", dv_cnt, dvc);
      check("drop_no_req", log_q.size(), sz);
      check("drop_x", data_x_o, px);
      check("drop_y", data_y_o, py);
      check("drop_z", data_z_o, pz);
      check("drop_init", init_done_o, 0);
      check("drop_busy", busy_o, 0);
    end

    // DEVID mismatch
    regs[0] = 8'hE4; sz = log_q.size(); enable_i = 1'b1;
    for (int i = 0; i < 200 && !error_o; i++) tick();
    check("devid_err", error_o, 1);
    check("devid_txn", log_q.size(), sz + 1);
    if (log_q.size() > sz) check("devid_rd", key(log_q[sz]), {1'b1, 6'h00, 8'h00});
    repeat (1000) tick();
    check("err_no_req", log_q.size(), sz + 1);
    check("err_sticky", error_o, 1);
    check("err_init", init_done_o, 0);
    enable_i = 1'b0; repeat (2) tick();
    check("err_clear", error_o, 0);
    regs[0] = 8'hE5; sz = log_q.size(); enable_i = 1'b1;
    for (int i = 0; i < 50 && log_q.size() == sz; i++) tick();
    check("reen_devid", log_q.size() > sz ? key(log_q[sz]) : 15'h7FFF, {1'b1, 6'h00, 8'h00});
    for (int i = 0; i < 600 && !init_done_o; i++) tick();
    check("reen_init", init_done_o, 1);

    // PHY never acks: timeout
    noack = 1;
    for (int i = 0; i < 300 && !error_o; i++) tick();
    check("tmo_err", error_o, 1);
    check("tmo_latency", cyc - last_req_cyc, TMO);
    check("tmo_busy", busy_o, 0);
    sz = log_q.size(); repeat (200) tick();
    check("tmo_no_retry", log_q.size(), sz);
    enable_i = 1'b0; noack = 0; repeat (2) tick();
    check("tmo_clear", error_o, 0);

    // reset mid-burst
    random_sensor(); enable_i = 1'b1;
    for (int i = 0; i < 400 && !(req_o && addr_o == 6'h33); i++) tick();
    check("mid_req", {req_o, addr_o}, {1'b1, 6'h33});
    rst_i = 1'b1; tick();
    check_zero("midrst");
    rst_i = 1'b0; sz = log_q.size();
    for (int i = 0; i < 50 && log_q.size() == sz; i++) tick();
    check("rst_devid", log_q.size() > sz ? key(log_q[sz]) : 15'h7FFF, {1'b1, 6'h00, 8'h00});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/adxl345_seq.md
Name: adxl345_seq

Overview:
- Transaction sequencer for the ADXL345 accelerometer. It drives the parallel req/ack side of the SPI PHY and owns all register traffic to the sensor.
- After enable it checks DEVID, writes a fixed init table, then periodically reads the six acceleration bytes. X/Y/Z results are presented as signed 16-bit words with a one-cycle valid strobe.
- Sits between the PHY and the application logic. Only one PHY transaction is ever outstanding.

Parameters:
SAMPLE_DIV, 5000, idle clk_i cycles between end of one XYZ burst and start of the next (1 kHz at 5 MHz); legal range 1..2^20-1
BW_RATE_VAL, 8'h0A, value written to BW_RATE (0x2C)
DATA_FORMAT_VAL, 8'h40, value written to DATA_FORMAT (0x31); 3-wire SPI, +/-2 g
ACK_TIMEOUT, 64, max clk_i cycles from req_o pulse to ack_i before error; must be > 20

Ports:
clk_i  in  1  system clock, same clock as the PHY
rst_i  in  1  synchronous reset, active-high
enable_i  in  1  level; 1 = run sequence, 0 = return to IDLE at next transaction boundary
req_o  out  1  single-cycle transaction request to PHY
rw_no  out  1  1 = read, 0 = write; valid while req_o = 1
addr_o  out  6  sensor register address; valid while req_o = 1
wr_data_o  out  8  write data; valid while req_o = 1
ack_i  in  1  PHY completion pulse (one cycle)
rd_data_i  in  8  PHY read data, valid in the ack_i cycle
data_x_o  out  16  {DATAX1, DATAX0}
data_y_o  out  16  {DATAY1, DATAY0}
data_z_o  out  16  {DATAZ1, DATAZ0}
data_valid_o  out  1  one-cycle pulse; new X/Y/Z triple available
init_done_o  out  1  level; init table written, sampling active
busy_o  out  1  a PHY transaction is outstanding
error_o  out  1  sticky; DEVID mismatch or ack timeout

Behaviour:
- Reset (rst_i = 1 at posedge clk_i) clears everything to 0: all outputs, state = IDLE, period counter, timeout counter, sequence index. The PHY must be reset in the same window; there is no mid-transfer recovery.
- Request rule: req_o is high for exactly one cycle per transaction. It is never held, because a held request re-triggers the PHY after completion. rw_no, addr_o and wr_data_o are registered, set in the req_o cycle, and held until ack_i.
- busy_o rises with req_o and falls in the cycle after ack_i.
- Ack and timeout:
  - ack_i is accepted only in WAIT states; ack_i in any other state is ignored.
  - The timeout counter starts at req_o. If it reaches ACK_TIMEOUT without ack_i: error_o = 1, state = ERROR.
- States:
  - IDLE: enable_i = 1 -> DEVID.
  - DEVID: issue read 0x00; wait ack. rd_data_i == 8'hE5 -> INIT with idx = 0. Otherwise error_o = 1 -> ERROR.
  - INIT: issue writes in order 0x2C <= BW_RATE_VAL, 0x31 <= DATA_FORMAT_VAL, 0x2D <= 8'h08 (measure). After the third ack: init_done_o = 1, period counter loaded with SAMPLE_DIV, go to SLEEP.
  - SLEEP: decrement the period counter. Reaching 0 -> READ with idx = 0.
  - READ: issue reads 0x32..0x37, one per transaction. Capture bytes into a staging register. On the sixth ack, copy all three words to data_x/y/z_o in the same edge. data_valid_o pulses the following cycle. Reload the period counter -> SLEEP.
  - ERROR: all requests stop and error_o holds. enable_i = 0 -> IDLE, error_o and init_done_o cleared. Only a fresh enable rising re-runs DEVID.
- Output update: data_*_o update only on burst completion and never show a partially read triple. They keep their last values through SLEEP, IDLE and ERROR.
- enable_i falling:
  - With a transaction outstanding, wait for its ack (or timeout), then go to IDLE.
  - Any partial burst is discarded (no data_valid_o), and init_done_o is cleared on entering IDLE.
  - In SLEEP, go to IDLE next cycle.
  - Re-enable always restarts from DEVID.
- Turnaround: a new req_o is never issued in the ack_i cycle. The earliest next req_o is 2 cycles after ack_i, which lets the PHY chip select deassert.
- Counter widths: the period counter is 20 bits, the timeout counter is clog2(ACK_TIMEOUT+1) bits. No wrap; both saturate at 0.

Test Plan:
- Reset, enable_i = 1, PHY model returns 8'hE5: bench observes reads 0x00, then writes (0x2C, 8'h0A), (0x31, 8'h40), (0x2D, 8'h08) in order, each req_o exactly one cycle. init_done_o rises after the third ack.
- DEVID read returns 8'hE4: error_o = 1, no further req_o for 1000 cycles. Drop enable_i, then re-enable: error_o clears and DEVID is re-read.
- Sampling with SAMPLE_DIV = 10, sensor bytes 0x32..0x37 = 01, 80, FF, 7F, 34, 12: data_x_o = 16'h8001, data_y_o = 16'h7FFF, data_z_o = 16'h1234. data_valid_o is a one-cycle pulse; the next burst's first req_o is 10 cycles after the sixth ack plus state overhead.
- PHY model never acks a request, ACK_TIMEOUT = 64: error_o asserts exactly 64 cycles after req_o, busy_o drops, no retry.
- enable_i dropped during the third READ transaction: that ack completes, no data_valid_o, outputs keep previous values, state IDLE, init_done_o = 0.
- rst_i asserted mid-burst for one cycle: all outputs are 0 at the next edge; after release with enable_i = 1 the sequence restarts at DEVID read.
